// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared types and helpers for the MDR operation sequencer
//
// Purpose : operand width, operation/error/state encodings and two small
//           helpers used by the sequencer and its bus interface.
// Contents: DW, op_e, err_e, seq_state_e, unit_onehot(), add_mode()
package mdr_pkg;

   localparam int DW = 16;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_DIV  = 2'b01,
      OP_SQRT = 2'b10,
      OP_BAD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ERR_BAD_OP   = 2'd0,
      ERR_DIV_ZERO = 2'd1,
      ERR_SQRT_NEG = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_X,
      WAIT_Y,
      CHECK,
      RUN,
      DONE,
      ERR
   } seq_state_e;

   // One-hot unit select; OP_BAD maps to no unit at all.
   function automatic logic [2:0] unit_onehot(op_e op);
      return 3'b001 << op;
   endfunction

   // Shared adder direction while a unit is running.
   function automatic logic add_mode(op_e op, logic sqrt_add);
      case (op)
         OP_MUL:  return 1'b1;
         OP_DIV:  return 1'b0;
         OP_SQRT: return sqrt_add;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mdr_op_sequencer_if.sv
// rtl/mdr_op_sequencer_if.sv - control/operand bus between the MDR top and its sequencer
//
// Purpose : bundles the Start/Load/Op pins, the operand bus, the unit
//           handshakes and the sequencer's registered control outputs.
// Modports: seq  - the sequencer (drives control outputs)
//           ctrl - the environment (drives pins, operand bus, unit status)
interface mdr_op_sequencer_if;
   import mdr_pkg::*;

   logic          start;
   logic          load;
   logic [1:0]    op;
   logic [DW-1:0] data;
   logic [2:0]    unit_done;
   logic          sqrt_add;

   logic          load_op;
   logic          sync_clr;
   logic          load_x;
   logic          load_y;
   logic [2:0]    unit_start;
   logic [1:0]    adder_sel;
   logic          adder_add;
   logic          busy;
   logic          ready;
   logic          error;
   logic [1:0]    err_code;

   modport seq (
      input  start, load, op, data, unit_done, sqrt_add,
      output load_op, sync_clr, load_x, load_y, unit_start,
             adder_sel, adder_add, busy, ready, error, err_code
   );

   modport ctrl (
      output start, load, op, data, unit_done, sqrt_add,
      input  load_op, sync_clr, load_x, load_y, unit_start,
             adder_sel, adder_add, busy, ready, error, err_code
   );

endinterface

// File: rtl/mdr_edge_det.sv
// rtl/mdr_edge_det.sv - rising-edge detector for the Load pin
//
// Purpose : remembers the previous level of d and flags a 0->1 change
//           in the cycle the new level is seen.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous reset, active-low
//           d    - level input
//           rise - high for exactly one cycle per rising edge of d
module mdr_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) d_q <= 1'b0;
      else      d_q <= d;
   end

   // Combined with the registered previous level so the FSM can act in
   // the same cycle and produce its registered pulse one cycle later.
   assign rise = d & ~d_q;

endmodule

// File: rtl/mdr_op_sequencer.sv
// rtl/mdr_op_sequencer.sv - control sequencer for the multiply/divide/sqrt unit
//
// Purpose : collects X and Y from the shared data bus, validates them,
//           starts one arithmetic unit, steers the shared adder and
//           reports ready or error.  All outputs are registered.
// Ports   : clk         - clock, rising edge
//           rst         - asynchronous reset, active-low
//           bus (seq)   - start/load/op/data/unit_done/sqrt_add in;
//                         load_op/sync_clr/load_x/load_y/unit_start/
//                         adder_sel/adder_add/busy/ready/error/err_code out
// Options : MDR_TIMEOUT_EN - builds a RUN watchdog of TIMEOUT_CYC cycles
module mdr_op_sequencer
   import mdr_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic            clk,
   input  logic            rst,
   mdr_op_sequencer_if.seq bus
);

   seq_state_e state;
   op_e        op_q;
   logic       neg_x;
   logic       zero_y;
   logic       load_rise;

`ifdef MDR_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] run_cnt;
`endif

   mdr_edge_det u_load_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.load),
      .rise (load_rise)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         op_q           <= OP_MUL;
         neg_x          <= 1'b0;
         zero_y         <= 1'b0;
         bus.load_op    <= 1'b0;
         bus.sync_clr   <= 1'b0;
         bus.load_x     <= 1'b0;
         bus.load_y     <= 1'b0;
         bus.unit_start <= 3'b000;
         bus.adder_sel  <= 2'b00;
         bus.adder_add  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.ready      <= 1'b0;
         bus.error      <= 1'b0;
         bus.err_code   <= 2'b00;
`ifdef MDR_TIMEOUT_EN
         run_cnt        <= '0;
`endif
      end else begin
         // Pulses last one cycle; adder parks at sel=00/add outside RUN.
         bus.load_op    <= 1'b0;
         bus.sync_clr   <= 1'b0;
         bus.load_x     <= 1'b0;
         bus.load_y     <= 1'b0;
         bus.unit_start <= 3'b000;
         bus.adder_sel  <= 2'b00;
         bus.adder_add  <= 1'b1;

         case (state)
            IDLE, DONE, ERR: begin
               // A load edge arriving with start is dropped: edges are
               // only honoured once WAIT_X has been reached.
               if (bus.start) begin
                  bus.load_op  <= 1'b1;
                  bus.sync_clr <= 1'b1;
                  op_q         <= op_e'(bus.op);
                  bus.ready    <= 1'b0;
                  bus.error    <= 1'b0;
                  bus.err_code <= 2'b00;
                  bus.busy     <= 1'b1;
                  state        <= WAIT_X;
               end
            end

            WAIT_X: begin
               if (load_rise) begin
                  bus.load_x <= 1'b1;
                  neg_x      <= bus.data[DW-1];
                  state      <= (op_q == OP_SQRT) ? CHECK : WAIT_Y;
               end
            end

            WAIT_Y: begin
               if (load_rise) begin
                  bus.load_y <= 1'b1;
                  zero_y     <= (bus.data == '0);
                  state      <= CHECK;
               end
            end

            CHECK: begin
               if (op_q == OP_BAD) begin
                  bus.error    <= 1'b1;
                  bus.err_code <= ERR_BAD_OP;
                  bus.busy     <= 1'b0;
                  state        <= ERR;
               end else if (op_q == OP_DIV && zero_y) begin
                  bus.error    <= 1'b1;
                  bus.err_code <= ERR_DIV_ZERO;
                  bus.busy     <= 1'b0;
                  state        <= ERR;
               end else if (op_q == OP_SQRT && neg_x) begin
                  bus.error    <= 1'b1;
                  bus.err_code <= ERR_SQRT_NEG;
                  bus.busy     <= 1'b0;
                  state        <= ERR;
               end else begin
                  bus.unit_start <= unit_onehot(op_q);
                  bus.adder_sel  <= op_q;
                  bus.adder_add  <= add_mode(op_q, bus.sqrt_add);
`ifdef MDR_TIMEOUT_EN
                  run_cnt        <= '0;
`endif
                  state          <= RUN;
               end
            end

            RUN: begin
               // Only the selected unit's done bit counts; done beats timeout.
               if (|(bus.unit_done & unit_onehot(op_q))) begin
                  bus.ready <= 1'b1;
                  bus.busy  <= 1'b0;
                  state     <= DONE;
               end
`ifdef MDR_TIMEOUT_EN
               else if (run_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  bus.error    <= 1'b1;
                  bus.err_code <= ERR_TIMEOUT;
                  bus.busy     <= 1'b0;
                  state        <= ERR;
               end
`endif
               else begin
                  bus.adder_sel <= op_q;
                  bus.adder_add <= add_mode(op_q, bus.sqrt_add);
`ifdef MDR_TIMEOUT_EN
                  run_cnt       <= run_cnt + 1'b1;
`endif
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdr_op_sequencer.sv
// tb/tb_mdr_op_sequencer.sv - self-checking bench for mdr_op_sequencer
module tb_mdr_op_sequencer;
   import mdr_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mdr_op_sequencer_if bus ();

   mdr_op_sequencer #(.TIMEOUT_CYC(40)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse counters, sampled on the falling edge.
   int n_lop = 0, n_clr = 0, n_lx = 0, n_ly = 0, n_us = 0;
   always @(negedge clk) begin
      if (bus.load_op)     n_lop++;
      if (bus.sync_clr)    n_clr++;
      if (bus.load_x)      n_lx++;
      if (bus.load_y)      n_ly++;
      if (|bus.unit_start) n_us++;
   end

   function automatic logic [14:0] all_outs();
      return {bus.load_op, bus.sync_clr, bus.load_x, bus.load_y, bus.unit_start,
              bus.adder_sel, bus.adder_add, bus.busy, bus.ready, bus.error, bus.err_code};
   endfunction

   typedef struct packed {
      logic       is_err;
      logic [1:0] code;
   } res_t;
   res_t sbq[$];

   typedef struct {
      logic [1:0]  op;
      logic [15:0] x;
      logic [15:0] y;
      int          delay;
      logic        is_err;
      logic [1:0]  code;
   } vec_t;
   vec_t vecs[8];

   // Guarantees load is low at one rising edge before the new edge.
   task automatic drive_load(input logic [15:0] v);
      bus.load = 1'b0;
      tick;
      bus.data = v;
      bus.load = 1'b1;
      tick;
      bus.load = 1'b0;
   endtask

   task automatic run_op(input vec_t v);
      int lop0, clr0, lx0, ly0, us0;
      logic sa;
      logic [2:0] oh;
      res_t r;
      lop0 = n_lop; clr0 = n_clr; lx0 = n_lx; ly0 = n_ly; us0 = n_us;
      oh = 3'b001 << v.op;
      bus.op    = v.op;
      bus.start = 1'b1;
      sbq.push_back(res_t'{v.is_err, v.code});
      tick;
      bus.start = 1'b0;
      chk("start_busy", bus.busy, 1);
      chk("start_ready_clr", bus.ready, 0);
      chk("start_error_clr", bus.error, 0);
      drive_load(v.x);
      chk("load_x_pulse", bus.load_x, 1);
      if (v.op != OP_SQRT) begin
         drive_load(v.y);
         chk("load_y_pulse", bus.load_y, 1);
      end
      tick;  // CHECK cycle
      if (!v.is_err) begin
         chk("unit_start", bus.unit_start, oh);
         chk("run_adder_sel", bus.adder_sel, v.op);
         chk("run_adder_add0", bus.adder_add, (v.op == OP_DIV) ? 1'b0 : 1'b1);
         for (int i = 0; i < v.delay; i++) begin
            sa = 1'($urandom_range(0, 1));
            bus.sqrt_add  = sa;
            bus.unit_done = (i == 0) ? (~oh & 3'b111) : 3'b000;
            tick;
            chk("run_busy", bus.busy, 1);
            chk("run_adder_add", bus.adder_add, (v.op == OP_SQRT) ? sa : (v.op == OP_MUL));
         end
         bus.unit_done = oh;
         bus.sqrt_add  = 1'b1;
         tick;
         bus.unit_done = 3'b000;
      end
      r = sbq.pop_front();
      chk("ready", bus.ready, !r.is_err);
      chk("error", bus.error, r.is_err);
      if (r.is_err) chk("err_code", bus.err_code, r.code);
      chk("end_busy", bus.busy, 0);
      chk("end_adder", {bus.adder_sel, bus.adder_add}, 3'b001);
      chk("cnt_load_op", n_lop - lop0, 1);
      chk("cnt_sync_clr", n_clr - clr0, 1);
      chk("cnt_load_x", n_lx - lx0, 1);
      chk("cnt_load_y", n_ly - ly0, (v.op != OP_SQRT) ? 1 : 0);
      chk("cnt_unit_start", n_us - us0, v.is_err ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lx0, ly0;
      vecs[0] = '{2'b00, 16'd7,     16'd6,   17, 1'b0, 2'd0};
      vecs[1] = '{2'b01, 16'd100,   16'd0,    0, 1'b1, 2'd1};
      vecs[2] = '{2'b10, 16'd144,   16'd0,    5, 1'b0, 2'd0};
      vecs[3] = '{2'b10, 16'h8000,  16'd0,    0, 1'b1, 2'd2};
      vecs[4] = '{2'b11, 16'd1,     16'd1,    0, 1'b1, 2'd0};
      vecs[5] = '{2'b01, 16'd100,   16'd7,    3, 1'b0, 2'd0};
      vecs[6] = '{2'b00, 16'hFFFF,  16'd0,    1, 1'b0, 2'd0};
      vecs[7] = '{2'b01, 16'h8000,  16'd3,    2, 1'b0, 2'd0};

      bus.start = 0; bus.load = 0; bus.op = 0; bus.data = 0;
      bus.unit_done = 0; bus.sqrt_add = 1;

      // Reset state
      #12;
      chk("reset_outputs", all_outs(), 15'd0);
      tick;
      rst = 1'b1;
      tick;
      chk("idle_adder", {bus.adder_sel, bus.adder_add}, 3'b001);
      chk("idle_busy", bus.busy, 0);

      foreach (vecs[i]) run_op(vecs[i]);

      // Start together with a load edge; load held high many cycles.
      lx0 = n_lx; ly0 = n_ly;
      bus.op = OP_DIV; bus.start = 1'b1; bus.load = 1'b1; bus.data = 16'd5;
      tick;
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) tick;
      chk("start_edge_discarded", n_lx - lx0, 0);
      bus.load = 1'b0;
      tick;
      bus.load = 1'b1;
      for (int i = 0; i < 10; i++) tick;
      bus.load = 1'b0;
      chk("held_load_one_pulse", n_lx - lx0, 1);
      chk("held_load_no_y", n_ly - ly0, 0);
      drive_load(16'd2);
      chk("held_seq_load_y", bus.load_y, 1);
      tick;
      chk("held_seq_unit_start", bus.unit_start, 3'b010);
      for (int i = 0; i < 39; i++) tick;
      chk("run39_busy", bus.busy, 1);
      chk("run39_no_error", bus.error, 0);
      tick;
`ifdef MDR_TIMEOUT_EN
      chk("timeout_error", bus.error, 1);
      chk("timeout_code", bus.err_code, 2'd3);
      chk("timeout_not_ready", bus.ready, 0);
      chk("timeout_busy", bus.busy, 0);
`else
      for (int i = 0; i < 60; i++) tick;
      chk("no_timeout_busy", bus.busy, 1);
      chk("no_timeout_error", bus.error, 0);
      bus.unit_done = 3'b010;
      tick;
      bus.unit_done = 3'b000;
      chk("late_done_ready", bus.ready, 1);
`endif

      // Done arriving on the 40th RUN cycle wins over any timeout.
      bus.op = OP_DIV; bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      drive_load(16'd9);
      drive_load(16'd3);
      tick;
      chk("edge40_unit_start", bus.unit_start, 3'b010);
      for (int i = 0; i < 39; i++) tick;
      bus.unit_done = 3'b010;
      tick;
      bus.unit_done = 3'b000;
      chk("edge40_ready", bus.ready, 1);
      chk("edge40_no_error", bus.error, 0);

      // Reset asserted in RUN
      bus.op = OP_MUL; bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      drive_load(16'd3);
      drive_load(16'd4);
      tick;
      chk("rst_seq_unit_start", bus.unit_start, 3'b001);
      tick; tick;
      #2 rst = 1'b0;
      #1;
      chk("rst_in_run_outputs", all_outs(), 15'd0);
      #3 rst = 1'b1;
      tick;
      chk("after_rst_busy", bus.busy, 0);
      drive_load(16'd9);
      chk("after_rst_load_ignored", bus.load_x, 0);
      run_op(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
